pool_relu_multi: RTL and testbench
==================================

Name: pool_relu_multi

Overview:
- Parametrised successor to the per-channel pool/ReLU stage.
- NCH lockstep channels each take a raster-scanned W x H feature map and perform 2x2 stride-2 pooling (max or average) with optional ReLU, producing (W/2) x (H/2) results per channel.
- Sits between the convolution engine output and the next layer's input buffer.
- Owns its own row/column tracking and line buffering, and flags the end of each frame.

Parameters:
- In_d_W, 32, signed data width per channel.
- W, 26, input row width in pixels; must be even.
- H, 26, input rows per frame; must be even.
- NCH, 4, number of parallel channels.
- MODE, 0, pooling mode: 0 = max, 1 = average.
- RELU_EN, 1, ReLU control: 1 = clamp negative results to 0; 0 = bypass.

Ports:
- iClk, input, 1, clock.
- iRsn, input, 1, synchronous active-high reset.
- iValid, input, 1, input beat valid; qualifies all channels together.
- iData, input, NCH*In_d_W, packed signed pixels; channel k at [k*In_d_W +: In_d_W].
- oValid, output, 1, pooled result valid; one-cycle pulse per result.
- oData, output, NCH*In_d_W, packed signed pooled results; same packing as iData.
- oFrameDone, output, 1, pulses together with the last result of a frame.

Behaviour:
- Reset: one clock, synchronous, active-high. iRsn is sampled at posedge iClk; when high:
  - oValid=0, oFrameDone=0, oData=0.
  - col=0, row=0, hold registers cleared.
  - Line-buffer contents are don't-care (never read before being rewritten).
- Counters:
  - col runs 0..W-1 and row runs 0..H-1; both advance only on iValid.
  - col wraps to 0 and row increments.
  - At row=H-1, col=W-1, both wrap to 0, so frames run back-to-back with no gap.
- Per channel on each iValid beat:
  - col even: hold <= pixel.
  - col odd: pair = max(hold, pixel) in MODE 0, or hold+pixel at In_d_W+1 bits in MODE 1.
  - row even, col odd: linebuf[col/2] <= pair (sign-extended to In_d_W+1 bits).
  - row odd, col odd: result = max(linebuf[col/2], pair), or (linebuf[col/2]+pair) at In_d_W+2 bits, arithmetic-shifted right by 2 (floor) and truncated to In_d_W. Average cannot overflow.
- ReLU: if RELU_EN and result<0, result=0.
- Output timing:
  - The result is registered, so oValid is asserted in the cycle after the input beat that completes the window (row odd, col odd). Latency is 1 cycle.
  - oData updates only when oValid is asserted and holds its value otherwise.
- oFrameDone: asserted in the same cycle as oValid for the window whose completing beat was at row=H-1, col=W-1.
- Bubbles: iValid=0 for any number of cycles freezes all state; results are identical to a gap-free stream.
- No backpressure; the downstream block must accept one result per cycle.
- Reset mid-frame: takes effect at the next edge. Any result in flight is dropped (oValid=0 in the cycle after reset). The next beat after reset is treated as row 0, col 0.
- Line buffer: W/2 entries x (In_d_W+1) bits per channel, implemented in registers or distributed RAM.

Decomposition:
- Shared package pool_pkg:
  - MODE_MAX=0 and MODE_AVG=1 constants.
  - Signed max function.
  - Index width function clog2(W), clog2(H).
- Top level: col/row counters, window-complete/frame-end decode, oValid/oFrameDone registers.
- Sub-module pool_relu_lane, generated NCH times. Contents: hold register, line buffer, compare/sum, ReLU, output data register.
- Lane inputs: pixel, beat strobe, col-even/row-odd flags, buffer index.

Test Plan:
- Max mode: W=H=4, NCH=2, RELU_EN=1, MODE=0. ch0 pixels 1..16 raster, gap-free.
  -> oValid one cycle after beats 5, 7, 13, 15.
  -> ch0 = 6, 8, 14, 16.
  -> oFrameDone only with 16.
- Negative data: W=H=4, NCH=2, MODE=0. ch1 all -5, ch0 all 3.
  -> RELU_EN=1: ch1=0, ch0=3.
  -> RELU_EN=0: ch1=-5.
- Average mode, MODE=1, first window:
  - Window {1,2,5,6} -> 3.
  - Window {-1,-2,-5,-6} -> 0 with RELU_EN=1; -4 (floor) with RELU_EN=0.
  - All four pixels 0x7FFFFFFF -> 0x7FFFFFFF, no overflow.
- Bubbles: repeat the max-mode scenario with 3 idle cycles after every beat.
  -> Identical values 6, 8, 14, 16.
  -> Each oValid exactly 1 cycle after its completing beat.
  -> No spurious pulses during gaps.
- Reset mid-frame: iRsn=1 for one cycle after beat 6, then a fresh frame 1..16.
  -> oValid=0, oData=0 the cycle after reset.
  -> Fresh frame gives exactly 6, 8, 14, 16; no stale line-buffer data appears.
- Back-to-back frames: two 4x4 frames with no gap.
  -> 8 results; oFrameDone pulses twice (4th and 8th results).
  -> The second frame's results are unaffected by the first.

Source files
------------

// File: rtl/pool_pkg.sv
// pool_pkg: shared constants and helpers for the pool/ReLU stage
package pool_pkg;
    localparam int MODE_MAX = 0;
    localparam int MODE_AVG = 1;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic logic signed [63:0] smax(input logic signed [63:0] a, input logic signed [63:0] b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/pool_relu_lane.sv
// pool_relu_lane: one channel of 2x2 pooling with hold register, line buffer and ReLU
module pool_relu_lane import pool_pkg::*; #(
    parameter int DW = 32,
    parameter int W = 26,
    parameter int MODE = MODE_MAX,
    parameter int RELU_EN = 1,
    parameter int AW = idx_w(W / 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          beat_i,
    input  logic          col_even_i,
    input  logic          row_odd_i,
    input  logic [AW-1:0] idx_i,
    input  logic [DW-1:0] pixel_i,
    output logic [DW-1:0] data_o
);
    logic signed [DW-1:0] hold_q, data_q, pooled, res;
    logic signed [DW:0] lbuf_q [W/2];
    logic signed [DW:0] h_x, p_x, pair, lb;
    logic signed [DW+1:0] sum4;
    assign h_x = {hold_q[DW-1], hold_q};
    assign p_x = {pixel_i[DW-1], pixel_i};
    assign lb = lbuf_q[idx_i];
    assign pair = MODE == MODE_AVG ? h_x + p_x : (DW+1)'(smax(64'(h_x), 64'(p_x)));
    assign sum4 = {lb[DW], lb} + {pair[DW], pair};
    // average of four: floor division by 4 always fits back into DW bits
    assign pooled = MODE == MODE_AVG ? DW'(sum4 >>> 2) : DW'(smax(64'(lb), 64'(pair)));
    assign res = RELU_EN != 0 && pooled[DW-1] ? '0 : pooled;
    assign data_o = data_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            data_q <= '0;
        end else if (beat_i) begin
            if (col_even_i) hold_q <= pixel_i;
            else if (row_odd_i) data_q <= res;
        end
    end
    always_ff @(posedge clk) begin
        if (beat_i && !col_even_i && !row_odd_i) lbuf_q[idx_i] <= pair;
    end
endmodule

// File: rtl/pool_relu_multi.sv
// pool_relu_multi: NCH lockstep 2x2 stride-2 pooling lanes with shared raster tracking
module pool_relu_multi import pool_pkg::*; #(
    parameter int In_d_W = 32,
    parameter int W = 26,
    parameter int H = 26,
    parameter int NCH = 4,
    parameter int MODE = MODE_MAX,
    parameter int RELU_EN = 1
) (
    input  logic                    iClk,
    input  logic                    iRsn,
    input  logic                    iValid,
    input  logic [NCH*In_d_W-1:0]   iData,
    output logic                    oValid,
    output logic [NCH*In_d_W-1:0]   oData,
    output logic                    oFrameDone
);
    localparam int CW = idx_w(W);
    localparam int RW = idx_w(H);
    localparam int AW = idx_w(W / 2);
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic last_col, last_row, win, valid_q, done_q;
    assign last_col = col_q == CW'(W - 1);
    assign last_row = row_q == RW'(H - 1);
    assign win = iValid && col_q[0] && row_q[0];
    always_comb begin
        col_d = !iValid ? col_q : last_col ? '0 : col_q + CW'(1);
        row_d = !iValid || !last_col ? row_q : last_row ? '0 : row_q + RW'(1);
    end
    always_ff @(posedge iClk) begin
        col_q   <= iRsn ? '0 : col_d;
        row_q   <= iRsn ? '0 : row_d;
        valid_q <= !iRsn && win;
        done_q  <= !iRsn && win && last_col && last_row;
    end
    assign oValid = valid_q;
    assign oFrameDone = done_q;
    for (genvar g = 0; g < NCH; g++) begin : g_lane
        pool_relu_lane #(.DW(In_d_W), .W(W), .MODE(MODE), .RELU_EN(RELU_EN), .AW(AW)) u_lane (
            .clk        (iClk),
            .rst        (iRsn),
            .beat_i     (iValid),
            .col_even_i (!col_q[0]),
            .row_odd_i  (row_q[0]),
            .idx_i      (AW'(col_q >> 1)),
            .pixel_i    (iData[g*In_d_W +: In_d_W]),
            .data_o     (oData[g*In_d_W +: In_d_W])
        );
    end
endmodule

// File: tb/tb_pool_relu_multi.sv
// tb_pool_relu_multi: four configurations (max/avg x ReLU on/off) on one 4x4, 2-channel stream
module tb_pool_relu_multi;
    logic clk = 0, rst = 1, valid = 0;
    logic [63:0] data = '0;
    logic [3:0] ov, fd;
    logic [63:0] od [4];
    logic exp_v [4], exp_fd [4];
    logic [63:0] exp_d [4];
    logic [63:0] cap [4][$];
    int fdn [4];
    longint pix [2][4][4];
    int bi = 0, tests = 0, fails = 0;

    always #5 clk = ~clk;

    pool_relu_multi #(.In_d_W(32), .W(4), .H(4), .NCH(2), .MODE(0), .RELU_EN(1)) u0 (
        .iClk(clk), .iRsn(rst), .iValid(valid), .iData(data), .oValid(ov[0]), .oData(od[0]), .oFrameDone(fd[0]));
    pool_relu_multi #(.In_d_W(32), .W(4), .H(4), .NCH(2), .MODE(0), .RELU_EN(0)) u1 (
        .iClk(clk), .iRsn(rst), .iValid(valid), .iData(data), .oValid(ov[1]), .oData(od[1]), .oFrameDone(fd[1]));
    pool_relu_multi #(.In_d_W(32), .W(4), .H(4), .NCH(2), .MODE(1), .RELU_EN(1)) u2 (
        .iClk(clk), .iRsn(rst), .iValid(valid), .iData(data), .oValid(ov[2]), .oData(od[2]), .oFrameDone(fd[2]));
    pool_relu_multi #(.In_d_W(32), .W(4), .H(4), .NCH(2), .MODE(1), .RELU_EN(0)) u3 (
        .iClk(clk), .iRsn(rst), .iValid(valid), .iData(data), .oValid(ov[3]), .oData(od[3]), .oFrameDone(fd[3]));

    // cfg m: bit1 selects average, bit0 clear means ReLU on
    function automatic logic [31:0] pool(input int m, input int k, input int r, input int c);
        longint w [4], v;
        w[0] = pix[k][r-1][c-1]; w[1] = pix[k][r-1][c]; w[2] = pix[k][r][c-1]; w[3] = pix[k][r][c];
        if (m >= 2) v = (w[0] + w[1] + w[2] + w[3]) >>> 2;
        else begin
            v = w[0];
            for (int i = 1; i < 4; i++) if (w[i] > v) v = w[i];
        end
        if (m % 2 == 0 && v < 0) v = 0;
        return 32'(v);
    endfunction

    task automatic model_step();
        int r, c;
        if (rst) begin
            bi = 0;
            for (int m = 0; m < 4; m++) begin exp_v[m] = 0; exp_fd[m] = 0; exp_d[m] = '0; end
        end else begin
            for (int m = 0; m < 4; m++) begin exp_v[m] = 0; exp_fd[m] = 0; end
            if (valid) begin
                r = bi / 4; c = bi % 4;
                for (int k = 0; k < 2; k++) pix[k][r][c] = longint'($signed(data[k*32 +: 32]));
                if (r % 2 == 1 && c % 2 == 1)
                    for (int m = 0; m < 4; m++) begin
                        for (int k = 0; k < 2; k++) exp_d[m][k*32 +: 32] = pool(m, k, r, c);
                        exp_v[m] = 1;
                        exp_fd[m] = bi == 15;
                    end
                bi = (bi + 1) % 16;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            tests++;
            if (ov[m] !== exp_v[m] || fd[m] !== exp_fd[m] || od[m] !== exp_d[m]) begin
                fails++;
                $display("FAIL cycle cfg%0d t=%0t: got v=%b fd=%b d=%h, want v=%b fd=%b d=%h",
                         m, $time, ov[m], fd[m], od[m], exp_v[m], exp_fd[m], exp_d[m]);
            end
            if (ov[m] === 1'b1) cap[m].push_back(od[m]);
            if (fd[m] === 1'b1) fdn[m]++;
        end
    end

    task automatic chk(input string name, input longint act, input longint want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    function automatic longint ch(input logic [63:0] v, input int k);
        return longint'($signed(v[k*32 +: 32]));
    endfunction

    task automatic clear_caps();
        for (int m = 0; m < 4; m++) begin cap[m].delete(); fdn[m] = 0; end
    endtask

    task automatic send_frame(input int kind, input int gaps, input int nbeats);
        for (int i = 1; i <= nbeats; i++) begin
            valid = 1;
            data[31:0]  = kind == 0 ? 32'(i) : kind == 1 ? 32'd3 : 32'h7FFF_FFFF;
            data[63:32] = kind == 0 ? -32'(i) : -32'sd5;
            @(negedge clk);
            valid = 0;
            repeat (gaps) @(negedge clk);
        end
    endtask

    task automatic check_basic(input string tag);
        chk({tag, "_count"}, cap[0].size(), 4);
        if (cap[0].size() == 4) begin
            chk({tag, "_r0"}, ch(cap[0][0], 0), 6);
            chk({tag, "_r1"}, ch(cap[0][1], 0), 8);
            chk({tag, "_r2"}, ch(cap[0][2], 0), 14);
            chk({tag, "_r3"}, ch(cap[0][3], 0), 16);
        end
        chk({tag, "_fdn"}, fdn[0], 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        chk("reset_valid", longint'(ov), 0);
        chk("reset_data", longint'(od[0]), 0);
        clear_caps();
        send_frame(0, 0, 16);
        send_frame(1, 0, 16);
        send_frame(2, 0, 16);
        repeat (3) @(negedge clk);
        chk("b2b_count", cap[0].size(), 12);
        chk("b2b_fdn", fdn[0], 3);
        if (cap[0].size() == 12 && cap[1].size() == 12 && cap[2].size() == 12 && cap[3].size() == 12) begin
            chk("max_r0", ch(cap[0][0], 0), 6);
            chk("max_r1", ch(cap[0][1], 0), 8);
            chk("max_r2", ch(cap[0][2], 0), 14);
            chk("max_r3", ch(cap[0][3], 0), 16);
            chk("max_neg_relu", ch(cap[0][0], 1), 0);
            chk("max_neg_bypass", ch(cap[1][0], 1), -1);
            chk("avg_pos", ch(cap[2][0], 0), 3);
            chk("avg_neg_relu", ch(cap[2][0], 1), 0);
            chk("avg_neg_floor", ch(cap[3][0], 1), -4);
            chk("const_pos", ch(cap[0][4], 0), 3);
            chk("const_neg_relu", ch(cap[0][4], 1), 0);
            chk("const_neg_bypass", ch(cap[1][4], 1), -5);
            chk("avg_maxint", ch(cap[2][8], 0), 32'h7FFF_FFFF);
            chk("avg_const_neg", ch(cap[3][8], 1), -5);
            chk("f2_after_f1", ch(cap[0][7], 0), 3);
        end
        clear_caps();
        send_frame(0, 3, 16);
        repeat (3) @(negedge clk);
        check_basic("bubble");
        clear_caps();
        send_frame(0, 0, 6);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_valid", longint'(ov[0]), 0);
        chk("midrst_data", longint'(od[0]), 0);
        clear_caps();
        send_frame(0, 0, 16);
        repeat (3) @(negedge clk);
        check_basic("fresh");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit reached");
        $fatal(1);
    end
endmodule
